// File: rtl/edge_event_arbiter.sv
// Rising-edge event capture on N_CH lines with a round-robin single-slot output.
// Define EDGE_EVT_CNT_EN to add per-channel accepted-grant counters on evt_cnt.
module edge_event_arbiter #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 8,
    localparam int ID_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_CH-1:0]   in,
    input  logic              evt_ready,
    input  logic              clr_ovf,
    output logic              evt_valid,
    output logic [ID_W-1:0]   evt_id,
    output logic [N_CH-1:0]   pending,
    output logic [N_CH-1:0]   overflow
`ifdef EDGE_EVT_CNT_EN
    ,
    output logic [N_CH*CNT_W-1:0] evt_cnt
`endif
);

    if (N_CH < 2 || N_CH > 16) begin : g_bad_n_ch
        $error("edge_event_arbiter: N_CH must be in 2..16");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("edge_event_arbiter: CNT_W must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, RISE, HIGH} ch_state_e;

    ch_state_e         state     [N_CH];
    ch_state_e         state_nxt [N_CH];
    logic [N_CH-1:0]   rise_evt;
    logic [N_CH-1:0]   gnt;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   sel_id;
    logic [ID_W-1:0]   cand;
    logic              found;
    logic              loadable;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) state[i] <= IDLE;
        end else begin
            for (int i = 0; i < N_CH; i++) state[i] <= state_nxt[i];
        end
    end

    // An edge is only recognised from IDLE, so a held level needs a sampled low to re-arm.
    always_comb begin
        rise_evt = '0;
        for (int i = 0; i < N_CH; i++) begin
            state_nxt[i] = state[i];
            unique case (state[i])
                IDLE: if (in[i]) begin
                    state_nxt[i] = RISE;
                    rise_evt[i]  = 1'b1;
                end
                RISE:    state_nxt[i] = in[i] ? HIGH : IDLE;
                HIGH:    if (!in[i]) state_nxt[i] = IDLE;
                default: state_nxt[i] = IDLE;
            endcase
        end
    end

    assign loadable = !evt_valid || evt_ready;

    // Round-robin search starts one past the last granted channel.
    always_comb begin
        found  = 1'b0;
        sel_id = '0;
        cand   = '0;
        gnt    = '0;
        for (int k = 1; k <= N_CH; k++) begin
            cand = ID_W'((int'(rr_ptr) + k) % N_CH);
            if (!found && pending[cand]) begin
                found  = 1'b1;
                sel_id = cand;
            end
        end
        if (found && loadable) gnt[sel_id] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending   <= '0;
            overflow  <= '0;
            evt_valid <= 1'b0;
            evt_id    <= '0;
            rr_ptr    <= ID_W'(N_CH - 1);
        end else begin
            // A fresh edge on the channel being granted re-queues instead of overflowing.
            pending  <= (pending & ~gnt) | rise_evt;
            overflow <= (clr_ovf ? '0 : overflow) | (rise_evt & pending & ~gnt);
            if (loadable) begin
                evt_valid <= found;
                if (found) begin
                    evt_id <= sel_id;
                    rr_ptr <= sel_id;
                end
            end
        end
    end

`ifdef EDGE_EVT_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_cnt <= '0;
        end else if (evt_valid && evt_ready) begin
            evt_cnt[int'(evt_id)*CNT_W +: CNT_W] <= evt_cnt[int'(evt_id)*CNT_W +: CNT_W] + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Self-checking bench for edge_event_arbiter: directed scenarios plus randomized
// traffic against a behavioural model (edge = line high after a sampled low).
module tb_edge_event_arbiter;

    localparam int N_CH  = 4;
    localparam int CNT_W = 8;
    localparam int ID_W  = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [N_CH-1:0]   in_bus = '0;
    logic              evt_ready = 1'b0;
    logic              clr_ovf = 1'b0;
    logic              evt_valid;
    logic [ID_W-1:0]   evt_id;
    logic [N_CH-1:0]   pending;
    logic [N_CH-1:0]   overflow;
`ifdef EDGE_EVT_CNT_EN
    logic [N_CH*CNT_W-1:0] evt_cnt;
`endif

    int checks = 0;
    int errors = 0;

    logic [N_CH-1:0] m_prev, m_pend, m_ovf;
    logic            m_valid;
    logic [ID_W-1:0] m_id, m_rr;
    int              m_cnt [N_CH];

    edge_event_arbiter #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
`ifdef EDGE_EVT_CNT_EN
        .evt_cnt   (evt_cnt),
`endif
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (in_bus),
        .evt_ready (evt_ready),
        .clr_ovf   (clr_ovf),
        .evt_valid (evt_valid),
        .evt_id    (evt_id),
        .pending   (pending),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_prev  = '0;
        m_pend  = '0;
        m_ovf   = '0;
        m_valid = 1'b0;
        m_id    = '0;
        m_rr    = ID_W'(N_CH - 1);
        for (int i = 0; i < N_CH; i++) m_cnt[i] = 0;
    endtask

    task automatic model_step();
        logic [N_CH-1:0] rise, gnt;
        bit found;
        int c;
        rise  = in_bus & ~m_prev;
        gnt   = '0;
        found = 0;
        if (m_valid && evt_ready) m_cnt[m_id] = (m_cnt[m_id] + 1) % (1 << CNT_W);
        if (!m_valid || evt_ready) begin
            for (int k = 1; k <= N_CH; k++) begin
                c = (int'(m_rr) + k) % N_CH;
                if (!found && m_pend[c]) begin
                    found  = 1;
                    gnt[c] = 1'b1;
                    m_id   = ID_W'(c);
                    m_rr   = ID_W'(c);
                end
            end
            m_valid = found;
        end
        m_ovf  = (clr_ovf ? '0 : m_ovf) | (rise & m_pend & ~gnt);
        m_pend = (m_pend & ~gnt) | rise;
        m_prev = in_bus;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        #2;
        rst_n     = 1'b0;
        in_bus    = '0;
        evt_ready = 1'b0;
        clr_ovf   = 1'b0;
        model_reset();
        #3;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        in_bus    = 4'b0010;
        evt_ready = 1'b1;
        model_reset();
        #1 rst_n = 1'b0;
        #2;
        checks++;
        if ({evt_valid, evt_id, pending, overflow} !== 11'd0) begin
            errors++;
            $display("FAIL reset_state got %b expected %b", {evt_valid, evt_id, pending, overflow}, 11'd0);
        end
        #4 rst_n = 1'b1;
        tick();
        checks++;
        if (pending !== 4'b0010 || evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL high_at_release got pending=%b valid=%b expected pending=0010 valid=0", pending, evt_valid);
        end
        in_bus = '0;
        tick();
        checks++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd1 || pending !== 4'b0) begin
            errors++;
            $display("FAIL release_grant got valid=%b id=%0d pending=%b expected 1 1 0000", evt_valid, evt_id, pending);
        end
        tick();
    endtask

    task automatic test_single_pulse();
        do_reset();
        evt_ready = 1'b1;
        in_bus = 4'b0001;
        tick();
        checks++;
        if (pending !== 4'b0001 || evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL pulse_capture got pending=%b valid=%b expected 0001 0", pending, evt_valid);
        end
        in_bus = '0;
        tick();
        checks++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd0 || pending !== 4'b0) begin
            errors++;
            $display("FAIL pulse_grant got valid=%b id=%0d pending=%b expected 1 0 0000", evt_valid, evt_id, pending);
        end
        tick();
        checks++;
        if (evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL pulse_one_cycle got valid=%b expected 0", evt_valid);
        end
    endtask

    task automatic test_held_level();
        int n = 0;
        do_reset();
        evt_ready = 1'b1;
        in_bus = 4'b0100;
        repeat (10) begin
            tick();
            if (evt_valid && evt_id == 2'd2) n++;
        end
        checks++;
        if (n != 1) begin
            errors++;
            $display("FAIL held_level_events got %0d expected 1", n);
        end
        checks++;
        if (overflow !== 4'b0) begin
            errors++;
            $display("FAIL held_level_ovf got %b expected 0000", overflow);
        end
        in_bus = '0;
        tick();
    endtask

    task automatic test_round_robin();
        do_reset();
        evt_ready = 1'b1;
        repeat (2) begin
            in_bus = 4'b1111;
            tick();
            in_bus = '0;
            for (int k = 0; k < N_CH; k++) begin
                tick();
                checks++;
                if (evt_valid !== 1'b1 || evt_id !== ID_W'(k)) begin
                    errors++;
                    $display("FAIL rr_order got valid=%b id=%0d expected 1 %0d", evt_valid, evt_id, k);
                end
            end
            tick();
            checks++;
            if (evt_valid !== 1'b0) begin
                errors++;
                $display("FAIL rr_drain got valid=%b expected 0", evt_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        in_bus = 4'b0010;
        tick();
        in_bus = '0;
        tick();
        for (int c = 0; c < 5; c++) begin
            in_bus = (c == 1) ? 4'b1000 : 4'b0000;
            tick();
            checks++;
            if (evt_valid !== 1'b1 || evt_id !== 2'd1) begin
                errors++;
                $display("FAIL bp_hold got valid=%b id=%0d expected 1 1", evt_valid, evt_id);
            end
        end
        checks++;
        if (pending !== 4'b1000) begin
            errors++;
            $display("FAIL bp_pending got %b expected 1000", pending);
        end
        evt_ready = 1'b1;
        tick();
        checks++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd3 || pending !== 4'b0) begin
            errors++;
            $display("FAIL bp_release got valid=%b id=%0d pending=%b expected 1 3 0000", evt_valid, evt_id, pending);
        end
        tick();
    endtask

    task automatic test_overflow();
        do_reset();
        in_bus = 4'b0001;
        tick();
        in_bus = '0;
        tick();
        in_bus = 4'b0010;
        tick();
        in_bus = '0;
        tick();
        in_bus = 4'b0010;
        tick();
        checks++;
        if (overflow !== 4'b0010 || pending !== 4'b0010) begin
            errors++;
            $display("FAIL ovf_set got ovf=%b pending=%b expected 0010 0010", overflow, pending);
        end
        in_bus  = '0;
        clr_ovf = 1'b1;
        tick();
        checks++;
        if (overflow !== 4'b0) begin
            errors++;
            $display("FAIL ovf_clear got %b expected 0000", overflow);
        end
        in_bus = 4'b0010;
        tick();
        checks++;
        if (overflow !== 4'b0010) begin
            errors++;
            $display("FAIL ovf_set_wins got %b expected 0010", overflow);
        end
        clr_ovf = 1'b0;
        in_bus  = '0;
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        in_bus = 4'b0111;
        tick();
        in_bus = '0;
        tick();
        checks++;
        if (evt_valid !== 1'b1 || pending !== 4'b0110) begin
            errors++;
            $display("FAIL mid_reset_setup got valid=%b pending=%b expected 1 0110", evt_valid, pending);
        end
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({evt_valid, evt_id, pending, overflow} !== 11'd0) begin
            errors++;
            $display("FAIL mid_reset got %b expected %b", {evt_valid, evt_id, pending, overflow}, 11'd0);
        end
`ifdef EDGE_EVT_CNT_EN
        checks++;
        if (evt_cnt !== '0) begin
            errors++;
            $display("FAIL mid_reset_cnt got %h expected 0", evt_cnt);
        end
`endif
        #2 rst_n = 1'b1;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 800; i++) begin
            if (i == 400) do_reset();
            in_bus    = in_bus ^ N_CH'($urandom & $urandom);
            evt_ready = ($urandom % 4) != 0;
            clr_ovf   = ($urandom % 16) == 0;
            tick();
            checks++;
            if ({evt_valid, evt_id, pending, overflow} !== {m_valid, m_id, m_pend, m_ovf}) begin
                errors++;
                $display("FAIL random cyc=%0d got v/id/pend/ovf=%b/%0d/%b/%b expected %b/%0d/%b/%b",
                         i, evt_valid, evt_id, pending, overflow, m_valid, m_id, m_pend, m_ovf);
            end
`ifdef EDGE_EVT_CNT_EN
            for (int c = 0; c < N_CH; c++) begin
                checks++;
                if (evt_cnt[c*CNT_W +: CNT_W] !== CNT_W'(m_cnt[c])) begin
                    errors++;
                    $display("FAIL random_cnt ch=%0d got %0d expected %0d", c, evt_cnt[c*CNT_W +: CNT_W], m_cnt[c]);
                end
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_single_pulse();
        test_held_level();
        test_round_robin();
        test_backpressure();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
